noc_credit_tx: RTL and testbench

NOC_CREDIT_TX -- requirements
Module: noc_credit_tx

---
 rtl/noc_credit_tx.sv | 115 +++++++++++
 tb/tb_noc_credit_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_tx.sv
// noc_credit_tx
// Credit-based flit transmitter placed in front of a router input port.
// Flits offered upstream are accepted whenever at least one downstream
// buffer slot is known to be free, and are forwarded one cycle later on a
// registered output stage. A small packet FSM locks the destination of the
// head flit so that body and tail flits always carry it.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake (in_ready depends on credits only)
//   data_in, dest_in    : flit payload and destination (dest used on heads)
//   is_tail_in          : last flit of the packet
//   send_out            : registered flit valid toward the router
//   data_out, dest_out,
//   is_tail_out         : registered flit fields (hold when send_out=0)
//   credit_in           : one-cycle pulse, one downstream slot freed
//   credits             : current credit count
//   busy                : a packet is open (FSM in BODY)
//   credit_overflow     : sticky, a credit arrived while already full
//   pkt_count           : number of tail flits sent, modulo 2^16
module noc_credit_tx #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 1,
    parameter int FLIT_BUFFER_DEPTH = 4,
    localparam int CW               = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    output logic                  send_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    input  logic                  credit_in,
    output logic [CW-1:0]         credits,
    output logic                  busy,
    output logic                  credit_overflow,
    output logic [15:0]           pkt_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam logic [CW-1:0] MAX_CREDITS = CW'(FLIT_BUFFER_DEPTH);

    state_t                state;
    logic [DEST_WIDTH-1:0] locked_dest;
    logic                  accept;

    // Ready is derived from registered credits only, so there is no
    // combinational path from in_valid or credit_in back to in_ready.
    assign in_ready = (credits != '0);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == BODY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            locked_dest     <= '0;
            credits         <= MAX_CREDITS;
            send_out        <= 1'b0;
            data_out        <= '0;
            dest_out        <= '0;
            is_tail_out     <= 1'b0;
            credit_overflow <= 1'b0;
            pkt_count       <= '0;
        end else begin
            send_out <= accept;

            if (accept) begin
                data_out    <= data_in;
                is_tail_out <= is_tail_in;
                // A flit accepted in IDLE is a head (possibly also a tail):
                // its destination is captured and forwarded directly.
                if (state == IDLE) begin
                    locked_dest <= dest_in;
                    dest_out    <= dest_in;
                    if (!is_tail_in) begin
                        state <= BODY;
                    end
                end else begin
                    dest_out <= locked_dest;
                    if (is_tail_in) begin
                        state <= IDLE;
                    end
                end
                if (is_tail_in) begin
                    pkt_count <= pkt_count + 16'd1;
                end
            end

            // A simultaneous accept and returned credit cancel out.
            // A credit arriving at full count is a protocol error: the
            // count saturates and the sticky flag records it.
            case ({accept, credit_in})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == MAX_CREDITS) begin
                        credit_overflow <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_credit_tx.sv
// tb_noc_credit_tx
// Self-checking bench for noc_credit_tx (DEPTH=4). A behavioural model
// tracks credits as an integer, the open/closed packet as a flag and the
// expected output flit; a compare process checks every output against it on
// each falling edge. Directed sequences add literal expectations.
module tb_noc_credit_tx;

    localparam int FW = 32;
    localparam int DW = 1;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] data_in = '0;
    logic [DW-1:0] dest_in = '0;
    logic          is_tail_in = 1'b0;
    logic          send_out;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          credit_in;
    logic          credit_drv = 1'b0;
    logic          loop_en = 1'b0;
    logic [CW-1:0] credits;
    logic          busy;
    logic          credit_overflow;
    logic [15:0]   pkt_count;

    int checks = 0;
    int failures = 0;

    // Loopback mode returns every sent flit as a credit in the same cycle
    // it appears on send_out.
    assign credit_in = loop_en ? send_out : credit_drv;

    always #5 clk = ~clk;

    noc_credit_tx #(
        .FLIT_WIDTH(FW),
        .DEST_WIDTH(DW),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .dest_in(dest_in),
        .is_tail_in(is_tail_in),
        .send_out(send_out),
        .data_out(data_out),
        .dest_out(dest_out),
        .is_tail_out(is_tail_out),
        .credit_in(credit_in),
        .credits(credits),
        .busy(busy),
        .credit_overflow(credit_overflow),
        .pkt_count(pkt_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_credits;
    bit          m_open;
    logic [DW-1:0] m_lock;
    int          m_pkts;
    bit          m_ovf;
    bit          e_send;
    logic [FW-1:0] e_data;
    logic [DW-1:0] e_dest;
    bit          e_tail;

    // inputs as seen during the cycle, captured mid-cycle
    bit          s_valid, s_tail, s_credit;
    logic [FW-1:0] s_data;
    logic [DW-1:0] s_dest;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_credits = DEPTH;
            m_open = 0;
            m_lock = '0;
            m_pkts = 0;
            m_ovf = 0;
            e_send = 0;
            e_data = '0;
            e_dest = '0;
            e_tail = 0;
        end else begin
            bit acc;
            acc = s_valid && (m_credits > 0);
            e_send = acc;
            if (acc) begin
                if (!m_open) m_lock = s_dest;
                e_data = s_data;
                e_dest = m_lock;
                e_tail = s_tail;
                if (s_tail) begin
                    m_open = 0;
                    m_pkts = (m_pkts + 1) % 65536;
                end else begin
                    m_open = 1;
                end
            end
            m_credits = m_credits - int'(acc) + int'(s_credit);
            if (m_credits > DEPTH) begin
                m_credits = DEPTH;
                m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("m_send", 32'(send_out), 32'(e_send));
        checkOutput("m_data", 32'(data_out), 32'(e_data));
        checkOutput("m_dest", 32'(dest_out), 32'(e_dest));
        checkOutput("m_tail", 32'(is_tail_out), 32'(e_tail));
        checkOutput("m_credits", 32'(credits), 32'(m_credits));
        checkOutput("m_ready", 32'(in_ready), 32'(m_credits != 0));
        checkOutput("m_busy", 32'(busy), 32'(m_open));
        checkOutput("m_ovf", 32'(credit_overflow), 32'(m_ovf));
        checkOutput("m_pkts", 32'(pkt_count), 32'(m_pkts));
        s_valid  = in_valid;
        s_data   = data_in;
        s_dest   = dest_in;
        s_tail   = is_tail_in;
        s_credit = credit_in;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input logic [FW-1:0] d, input logic [DW-1:0] ds,
                                 input bit t, input bit c);
        in_valid   = v;
        data_in    = d;
        dest_in    = ds;
        is_tail_in = t;
        credit_drv = c;
    endtask

    task automatic resetPulse();
        applyStimulus(0, '0, '0, 0, 0);
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nsend;

        // reset values
        #12;
        checkOutput("rst_credits", 32'(credits), 32'd4);
        checkOutput("rst_send", 32'(send_out), 32'd0);
        checkOutput("rst_data", 32'(data_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf", 32'(credit_overflow), 32'd0);
        checkOutput("rst_pkts", 32'(pkt_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("ready_after_rst", 32'(in_ready), 32'd1);

        // six offered single-flit packets, only four credits
        nsend = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 32'hA0 + 32'(i), '0, 1, 0);
            tick();
            if (send_out) nsend++;
        end
        checkOutput("drain_sends", 32'(nsend), 32'd4);
        checkOutput("drain_ready", 32'(in_ready), 32'd0);
        checkOutput("drain_credits", 32'(credits), 32'd0);
        checkOutput("drain_data_hold", data_out, 32'hA3);
        checkOutput("drain_pkts", 32'(pkt_count), 32'd4);

        // one credit back, then spend it
        applyStimulus(0, '0, '0, 0, 1);
        tick();
        checkOutput("one_credit", 32'(credits), 32'd1);
        checkOutput("one_ready", 32'(in_ready), 32'd1);
        applyStimulus(1, 32'h55, 1, 1, 0);
        tick();
        checkOutput("spend_credits", 32'(credits), 32'd0);
        checkOutput("spend_data", data_out, 32'h55);
        checkOutput("spend_dest", 32'(dest_out), 32'd1);
        applyStimulus(0, 32'h77, 0, 0, 0);
        tick();
        checkOutput("idle_send", 32'(send_out), 32'd0);
        checkOutput("idle_data_hold", data_out, 32'h55);

        // refill then overflow
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, '0, '0, 0, 1);
            tick();
        end
        checkOutput("refill_credits", 32'(credits), 32'd4);
        checkOutput("refill_ovf", 32'(credit_overflow), 32'd0);
        applyStimulus(0, '0, '0, 0, 1);
        tick();
        checkOutput("ovf_credits", 32'(credits), 32'd4);
        checkOutput("ovf_flag", 32'(credit_overflow), 32'd1);
        applyStimulus(0, '0, '0, 0, 0);
        tick();
        tick();
        checkOutput("ovf_sticky", 32'(credit_overflow), 32'd1);
        resetPulse();
        checkOutput("ovf_cleared", 32'(credit_overflow), 32'd0);

        // sustained loopback
        loop_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 32'h300 + 32'(i), 0, 1, 0);
            tick();
            checkOutput("loop_send", 32'(send_out), 32'd1);
            checkOutput("loop_credits_range", 32'(credits >= 3 && credits <= 4), 32'd1);
            checkOutput("loop_ready", 32'(in_ready), 32'd1);
        end
        checkOutput("loop_pkts", 32'(pkt_count), 32'd20);
        applyStimulus(0, '0, '0, 0, 0);
        tick();
        loop_en = 1'b0;
        resetPulse();

        // three-flit packet with locked destination
        applyStimulus(1, 32'h100, 1, 0, 0);
        tick();
        checkOutput("pkt_head_dest", 32'(dest_out), 32'd1);
        checkOutput("pkt_head_busy", 32'(busy), 32'd1);
        applyStimulus(1, 32'h101, 0, 0, 0);
        tick();
        checkOutput("pkt_body_dest", 32'(dest_out), 32'd1);
        checkOutput("pkt_body_busy", 32'(busy), 32'd1);
        checkOutput("pkt_body_pkts", 32'(pkt_count), 32'd0);
        applyStimulus(1, 32'h102, 0, 1, 0);
        tick();
        checkOutput("pkt_tail_dest", 32'(dest_out), 32'd1);
        checkOutput("pkt_tail_busy", 32'(busy), 32'd0);
        checkOutput("pkt_tail_flag", 32'(is_tail_out), 32'd1);
        checkOutput("pkt_tail_pkts", 32'(pkt_count), 32'd1);
        resetPulse();

        // reset in the middle of a packet
        applyStimulus(1, 32'h400, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h401, 0, 0, 0);
        tick();
        checkOutput("mid_busy", 32'(busy), 32'd1);
        checkOutput("mid_credits", 32'(credits), 32'd2);
        #2;
        applyStimulus(0, '0, '0, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_credits", 32'(credits), 32'd4);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_send", 32'(send_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(1, 32'h500, 1, 0, 0);
        tick();
        checkOutput("post_head_dest", 32'(dest_out), 32'd1);
        checkOutput("post_head_busy", 32'(busy), 32'd1);
        applyStimulus(1, 32'h501, 0, 1, 0);
        tick();
        checkOutput("post_tail_dest", 32'(dest_out), 32'd1);
        checkOutput("post_tail_pkts", 32'(pkt_count), 32'd1);
        applyStimulus(0, '0, '0, 0, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
